// File: rtl/seg7_scan_scroller.sv
// Multiplexed seven-segment driver with a small character buffer, static or
// scrolling display, per-digit decimal points and a frame-rate blink.
module seg7_scan_scroller #(
  parameter int NDIGITS    = 4,
  parameter int DEPTH      = 8,
  parameter int SCAN_DIV   = 4,
  parameter int SCROLL_DIV = 2
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [5:0]               wr_code,
  input  logic                     mode,
  input  logic                     blink,
  input  logic [NDIGITS-1:0]       dp_mask,
  output logic [7:0]               SEG,
  output logic [NDIGITS-1:0]       AN,
  output logic [$clog2(DEPTH):0]   len
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;

  function automatic logic [6:0] decode(input logic [5:0] code);
    logic [6:0] segs;
    case (code)
      6'd0:  segs = 7'h3f;
      6'd1:  segs = 7'h06;
      6'd2:  segs = 7'h5b;
      6'd3:  segs = 7'h4f;
      6'd4:  segs = 7'h66;
      6'd5:  segs = 7'h6d;
      6'd6:  segs = 7'h7d;
      6'd7:  segs = 7'h07;
      6'd8:  segs = 7'h7f;
      6'd9:  segs = 7'h6f;
      6'd10: segs = 7'h77;
      6'd11: segs = 7'h7c;
      6'd12: segs = 7'h39;
      6'd13: segs = 7'h5e;
      6'd14: segs = 7'h79;
      6'd15: segs = 7'h71;
      6'd16: segs = 7'h77;
      6'd17: segs = 7'h7c;
      6'd18: segs = 7'h39;
      6'd19: segs = 7'h58;
      6'd20: segs = 7'h5e;
      6'd21: segs = 7'h79;
      6'd22: segs = 7'h71;
      6'd23: segs = 7'h6f;
      6'd24: segs = 7'h76;
      6'd25: segs = 7'h74;
      6'd26: segs = 7'h10;
      6'd27: segs = 7'h06;
      6'd28: segs = 7'h1e;
      6'd29: segs = 7'h38;
      6'd30: segs = 7'h54;
      6'd31: segs = 7'h3f;
      6'd32: segs = 7'h5c;
      6'd33: segs = 7'h73;
      6'd34: segs = 7'h67;
      6'd35: segs = 7'h50;
      6'd36: segs = 7'h6d;
      6'd37: segs = 7'h78;
      6'd38: segs = 7'h3e;
      6'd39: segs = 7'h1c;
      6'd40: segs = 7'h6e;
      6'd41: segs = 7'h63;
      default: segs = 7'h00;
    endcase
    return segs;
  endfunction

  logic [5:0]         char_q [DEPTH];
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      offset_q, offset_d;
  logic [SW-1:0]      scan_q, scan_d;
  logic [DW-1:0]      digit_q, digit_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic               blink_ph_q, blink_ph_d;
  state_e             state_q, state_d;
  logic [7:0]         seg_q, seg_d;
  logic [NDIGITS-1:0] an_q, an_d;

  logic          wr_fire;
  logic          scan_wrap, digit_wrap, frame_wrap, frame_end, tick;
  logic [LW-1:0] pos;
  logic          blank;

  assign wr_ready = (len_q < LW'(DEPTH));
  assign wr_fire  = wr_valid && wr_ready && !clear && !reset;

  assign scan_wrap  = (scan_q == SW'(SCAN_DIV - 1));
  assign digit_wrap = (digit_q == DW'(NDIGITS - 1));
  assign frame_wrap = (frame_q == FW'(SCROLL_DIV - 1));
  assign frame_end  = scan_wrap && digit_wrap;
  assign tick       = frame_end && frame_wrap;

  // NOTE: always_comb blocks assign every output a default first so no latch is inferred.
  always_comb begin
    scan_d     = scan_wrap ? '0 : scan_q + 1'b1;
    digit_d    = digit_q;
    frame_d    = frame_q;
    blink_ph_d = blink_ph_q ^ tick;
    if (scan_wrap) begin
      digit_d = digit_wrap ? '0 : digit_q + 1'b1;
    end
    if (frame_end) begin
      frame_d = frame_wrap ? '0 : frame_q + 1'b1;
    end
  end

  always_comb begin
    len_d    = len_q;
    state_d  = state_q;
    offset_d = offset_q;

    if (clear) begin
      len_d = '0;
    end else if (wr_fire) begin
      len_d = len_q + 1'b1;
    end

    // State follows the registered length and the live mode input.
    if (clear || len_q == '0) begin
      state_d = ST_EMPTY;
    end else if (mode) begin
      state_d = ST_SCROLL;
    end else begin
      state_d = ST_STATIC;
    end

    if (clear || state_q != ST_SCROLL || state_d != ST_SCROLL) begin
      offset_d = '0;
    end else if (tick) begin
      offset_d = (offset_q == len_q - 1'b1) ? '0 : offset_q + 1'b1;
    end
  end

  // Window position is a plain sum; anything past the stored text is blank.
  assign pos   = offset_q + LW'(digit_q);
  assign blank = (state_q == ST_EMPTY) || (pos >= len_q);

  always_comb begin
    seg_d = {dp_mask[digit_q], blank ? 7'h00 : decode(char_q[pos[AW-1:0]])};
    an_d  = NDIGITS'(1) << digit_q;
    if (state_q == ST_EMPTY) begin
      seg_d = 8'h00;
    end
    if (blink && blink_ph_q) begin
      seg_d = 8'h00;
    end
  end

  // NOTE: always_ff blocks use non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      len_q      <= '0;
      offset_q   <= '0;
      scan_q     <= '0;
      digit_q    <= '0;
      frame_q    <= '0;
      blink_ph_q <= 1'b0;
      state_q    <= ST_EMPTY;
      seg_q      <= 8'h00;
      an_q       <= '0;
    end else begin
      len_q      <= len_d;
      offset_q   <= offset_d;
      scan_q     <= scan_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
      blink_ph_q <= blink_ph_d;
      state_q    <= state_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  // NOTE: the character array has no reset; len alone decides which entries are meaningful.
  always_ff @(posedge clk_2) begin
    if (wr_fire) begin
      char_q[len_q[AW-1:0]] <= wr_code;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign len = len_q;

endmodule
